// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one registered magnitude comparator between two
// requesters. A round-robin arbiter picks a requester in IDLE, its operand
// pair is latched, the comparator runs in CMP, and RESULT publishes the
// tagged eq/lt/gt flags. One compare completes every 3 clocks.
module cmp_arbiter #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,
    output logic             busy,
    output logic             res_valid,
    output logic             res_id,
    output logic             res_eq,
    output logic             res_lt,
    output logic             res_gt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMP    = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_cur_id;
    logic             r_last_grant;
    logic             r_eq;
    logic             r_lt;
    logic             r_gt;

    logic             w_any_req;
    logic             w_win_id;
    logic [WIDTH-1:0] w_win_a;
    logic [WIDTH-1:0] w_win_b;
    logic [2:0]       w_flags;

    // Compare two operands; returns one-hot {gt, lt, eq}.
    function automatic logic [2:0] cmp_flags(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic lt_v;
        if (SIGNED) begin
            lt_v = ($signed(a) < $signed(b));
        end else begin
            lt_v = (a < b);
        end
        if (a == b) begin
            return 3'b001;
        end else if (lt_v) begin
            return 3'b010;
        end else begin
            return 3'b100;
        end
    endfunction

    // Round-robin winner selection: on contention the requester that did
    // not win last time is granted; a lone requester always wins.
    always_comb begin
        w_any_req = req0 | req1;
        w_win_id  = 1'b0;
        if (req0 && req1) begin
            w_win_id = ~r_last_grant;
        end else if (req0) begin
            w_win_id = 1'b0;
        end else begin
            w_win_id = 1'b1;
        end
        if (w_win_id) begin
            w_win_a = a1;
            w_win_b = b1;
        end else begin
            w_win_a = a0;
            w_win_b = b0;
        end
    end

    assign w_flags = cmp_flags(r_op_a, r_op_b);

    // Sequencer: grant/latch in IDLE, compare in CMP, publish in RESULT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_op_a       <= {WIDTH{1'b0}};
            r_op_b       <= {WIDTH{1'b0}};
            r_cur_id     <= 1'b0;
            r_last_grant <= 1'b1;
            r_eq         <= 1'b0;
            r_lt         <= 1'b0;
            r_gt         <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            res_id       <= 1'b0;
            res_eq       <= 1'b0;
            res_lt       <= 1'b0;
            res_gt       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    res_valid <= 1'b0;
                    if (w_any_req) begin
                        r_op_a   <= w_win_a;
                        r_op_b   <= w_win_b;
                        r_cur_id <= w_win_id;
                        ack0     <= ~w_win_id;
                        ack1     <= w_win_id;
                        busy     <= 1'b1;
                        r_state  <= ST_CMP;
                    end else begin
                        ack0    <= 1'b0;
                        ack1    <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CMP: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b1;
                    r_eq    <= w_flags[0];
                    r_lt    <= w_flags[1];
                    r_gt    <= w_flags[2];
                    r_state <= ST_RESULT;
                end
                ST_RESULT: begin
                    ack0         <= 1'b0;
                    ack1         <= 1'b0;
                    busy         <= 1'b0;
                    res_valid    <= 1'b1;
                    res_id       <= r_cur_id;
                    res_eq       <= r_eq;
                    res_lt       <= r_lt;
                    res_gt       <= r_gt;
                    r_last_grant <= r_cur_id;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    ack0      <= 1'b0;
                    ack1      <= 1'b0;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed testbench for cmp_arbiter. Two instances share all stimulus:
// u_uns (SIGNED=0) and u_sgn (SIGNED=1). Inputs change on the falling edge,
// outputs are checked on the falling edge.
module tb_cmp_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;

    logic u_ack0, u_ack1, u_busy, u_valid, u_id, u_eq, u_lt, u_gt;
    logic s_ack0, s_ack1, s_busy, s_valid, s_id, s_eq, s_lt, s_gt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cmp_arbiter #(.WIDTH(8), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .ack0(u_ack0),
        .req1(req1), .a1(a1), .b1(b1), .ack1(u_ack1),
        .busy(u_busy), .res_valid(u_valid), .res_id(u_id),
        .res_eq(u_eq), .res_lt(u_lt), .res_gt(u_gt)
    );

    cmp_arbiter #(.WIDTH(8), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .ack0(s_ack0),
        .req1(req1), .a1(a1), .b1(b1), .ack1(s_ack1),
        .busy(s_busy), .res_valid(s_valid), .res_id(s_id),
        .res_eq(s_eq), .res_lt(s_lt), .res_gt(s_gt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control outputs of both instances: {ack0, ack1, busy, res_valid}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk({tag, "/uns_ctl"}, {4'd0, u_ack0, u_ack1, u_busy, u_valid}, {4'd0, exp});
        chk({tag, "/sgn_ctl"}, {4'd0, s_ack0, s_ack1, s_busy, s_valid}, {4'd0, exp});
    endtask

    // Result fields {res_id, res_eq, res_lt, res_gt} per instance.
    task automatic chk_res(input string tag, input logic [3:0] exp_u, input logic [3:0] exp_s);
        chk({tag, "/uns_res"}, {4'd0, u_id, u_eq, u_lt, u_gt}, {4'd0, exp_u});
        chk({tag, "/sgn_res"}, {4'd0, s_id, s_eq, s_lt, s_gt}, {4'd0, exp_s});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
        #2;
        chk_ctl("reset_ctl", 4'b0000);
        chk_res("reset_res", 4'b0000, 4'b0000);
        tick();
        rst = 1'b1;
        tick();
        chk_ctl("idle_noreq", 4'b0000);

        // Contention: 4 grants alternating 0,1,0,1 (0: 3/3 eq, 1: 2/9 lt).
        req0 = 1'b1; a0 = 8'd3; b0 = 8'd3;
        req1 = 1'b1; a1 = 8'd2; b1 = 8'd9;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk_ctl($sformatf("cont_grant%0d", g), (g % 2 == 0) ? 4'b1010 : 4'b0110);
            if (g == 2) req0 = 1'b0;
            if (g == 3) req1 = 1'b0;
            tick();
            chk_ctl($sformatf("cont_cmp%0d", g), 4'b0010);
            tick();
            chk_ctl($sformatf("cont_valid%0d", g), 4'b0001);
            if (g % 2 == 0) chk_res($sformatf("cont_res%0d", g), 4'b0100, 4'b0100);
            else            chk_res($sformatf("cont_res%0d", g), 4'b1010, 4'b1010);
        end
        tick();
        chk_ctl("cont_done", 4'b0000);
        chk_res("cont_hold", 4'b1010, 4'b1010);

        // Lone requester 0: 20 vs 5, busy exactly 2 cycles.
        req0 = 1'b1; a0 = 8'd20; b0 = 8'd5;
        tick();
        chk_ctl("single_ack", 4'b1010);
        req0 = 1'b0;
        tick();
        chk_ctl("single_cmp", 4'b0010);
        tick();
        chk_ctl("single_valid", 4'b0001);
        chk_res("single_res", 4'b0001, 4'b0001);
        tick();
        chk_ctl("single_after", 4'b0000);
        chk_res("single_hold", 4'b0001, 4'b0001);

        // Signed boundary on requester 1: 0x80 vs 0x7F.
        req1 = 1'b1; a1 = 8'h80; b1 = 8'h7F;
        tick();
        chk_ctl("sign_ack", 4'b0110);
        req1 = 1'b0;
        tick();
        tick();
        chk_ctl("sign_valid", 4'b0001);
        chk_res("sign_res", 4'b1001, 4'b1010);

        // Operand change after ack does not affect in-flight compare.
        req0 = 1'b1; a0 = 8'd1; b0 = 8'd2;
        tick();
        chk_ctl("opchg_ack", 4'b1010);
        req0 = 1'b0; a0 = 8'd9;
        tick();
        tick();
        chk_ctl("opchg_valid", 4'b0001);
        chk_res("opchg_res", 4'b0010, 4'b0010);

        // Request 1 pulsed for one cycle while busy: never granted.
        req0 = 1'b1; a0 = 8'd5; b0 = 8'd5;
        tick();
        chk_ctl("wd_ack0", 4'b1010);
        req0 = 1'b0; req1 = 1'b1; a1 = 8'd1; b1 = 8'd0;
        tick();
        chk_ctl("wd_cmp", 4'b0010);
        req1 = 1'b0;
        tick();
        chk_ctl("wd_valid", 4'b0001);
        chk_res("wd_res", 4'b0100, 4'b0100);
        tick();
        chk_ctl("wd_idle1", 4'b0000);
        tick();
        chk_ctl("wd_idle2", 4'b0000);
        chk_res("wd_hold", 4'b0100, 4'b0100);

        // Reset during CMP: aborts, req1 held through reset is granted next.
        req1 = 1'b1; a1 = 8'd7; b1 = 8'd3;
        tick();
        chk_ctl("rst_ack1", 4'b0110);
        rst = 1'b0;
        #1;
        chk_ctl("rst_ctl", 4'b0000);
        chk_res("rst_res", 4'b0000, 4'b0000);
        tick();
        chk_ctl("rst_held", 4'b0000);
        rst = 1'b1;
        tick();
        chk_ctl("rst_regrant", 4'b0110);
        req1 = 1'b0;
        tick();
        chk_ctl("rst_cmp", 4'b0010);
        tick();
        chk_ctl("rst_valid", 4'b0001);
        chk_res("rst_res2", 4'b1001, 4'b1001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one registered magnitude comparator between two requesters.
- Round-robin arbiter plus a 3-state sequencer: grant a requester, latch its operand pair, run the registered compare, return tagged eq/lt/gt flags.
- Sits between client logic and the comparator datapath. Throughput is one compare per 3 clocks.

Parameters:
- WIDTH, 8, operand width in bits.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 request, level.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- ack0  out  1  one-cycle pulse: requester 0 operands captured.
- req1  in  1  requester 1 request, level.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- ack1  out  1  one-cycle pulse: requester 1 operands captured.
- busy  out  1  high whenever state is not IDLE.
- res_valid  out  1  one-cycle pulse: result flags valid.
- res_id  out  1  requester that owns the result.
- res_eq  out  1  A == B.
- res_lt  out  1  A < B.
- res_gt  out  1  A > B.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0.
  - State IDLE; operand registers 0; comparator flag registers 0.
  - last_grant = 1, so requester 0 wins the first contention.
- States: IDLE, CMP, RESULT. All outputs are registered.
- IDLE:
  - On a rising edge with req0 or req1 high, select the winner.
  - If only one request is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - Latch the winner's a/b into opA/opB and its id into cur_id.
  - Assert the winner's ack for exactly the next cycle. Go to CMP.
  - With no request, stay in IDLE; ack0 and ack1 stay 0.
- CMP:
  - Comparator registers update from opA/opB, signed or unsigned per SIGNED.
  - Exactly one of eq/lt/gt is set. Go to RESULT.
- RESULT:
  - res_valid high for this one cycle.
  - res_id = cur_id; res_eq/res_lt/res_gt = comparator flags.
  - last_grant <= cur_id. Go to IDLE.
- Latency: ack rises one cycle after req is sampled. res_valid rises 2 cycles after ack. Minimum req-to-res_valid is 3 edges.
- Flag hold: res_eq/lt/gt and res_id hold their last values after the res_valid pulse. They change only at the next RESULT cycle.
- Requester contract:
  - Keep req and operands stable until ack is seen.
  - Operands are sampled only at the IDLE grant edge; changes after that do not affect the in-flight result.
  - req still high after ack counts as a new request at the next IDLE. Back-to-back requests from one requester are legal.
- Request withdrawn before grant: nothing happens and no ack is issued.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A lone requester is granted every 3 cycles regardless of last_grant.
- Simultaneous events: a new req arriving in CMP or RESULT is not sampled until the next IDLE. It is never lost while held high.
- Reset mid-operation (CMP or RESULT):
  - Aborts immediately; no res_valid is emitted for the in-flight compare.
  - After release, pending requests are re-arbitrated from IDLE with last_grant = 1.
- Width rules: comparison covers the full WIDTH bits. With SIGNED=1, 8'h80 < 8'h7F; with SIGNED=0, 8'h80 > 8'h7F.

Test Plan:
- Single requester, WIDTH=8, SIGNED=0: req0 with a0=8'd20, b0=8'd5 → ack0 one cycle after grant; res_valid 2 cycles later with res_id=0, res_gt=1, res_eq=0, res_lt=0; busy high for exactly 2 cycles.
- Contention: req0 and req1 both held high for 4 grants; pair 0 is 3/3, pair 1 is 2/9 → grant order 0,1,0,1; results alternate eq (id 0) and lt (id 1); res_valid period is 3 cycles.
- Signed boundary: SIGNED=1, req1 with a1=8'h80, b1=8'h7F → res_lt=1, res_id=1. Same pair with SIGNED=0 → res_gt=1.
- Operand change after ack: req0 with a0=1, b0=2, then a0 changed to 9 in the cycle after ack0 → result is still res_lt=1.
- Reset mid-CMP: rst pulsed low during the CMP state → all outputs 0 immediately; no res_valid follows; req1 held high through reset is granted first after release.
- Request withdrawn: req1 pulsed for one cycle while the block is busy → no ack1 and no result with res_id=1.
